// File: rtl/aes256_round_seq.sv
// Round/step sequencer for the AES-256 core: drives the shared round and step counters,
// arbitrates the single S-box between key expansion and state columns, and runs the start/result handshake.
module aes256_round_seq #(
    parameter int NR        = 14,
    parameter int NSTEP     = 5,
    parameter int PARK_STEP = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hold,
    input  logic       out_ready,
    output logic       busy,
    output logic       out_valid,
    output logic       done,
    output logic [3:0] rnd_cnt,
    output logic [2:0] step,
    output logic       load_key,
    output logic       sbox_key,
    output logic       key_word_sel,
    output logic [1:0] col_idx,
    output logic       col_en,
    output logic       mix_en,
    output logic       first_rnd,
    output logic       last_rnd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [3:0] NR_C      = 4'(NR);
    localparam logic [2:0] LAST_STEP = 3'(NSTEP - 1);
    localparam logic [2:0] PARK_C    = 3'(PARK_STEP);

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [2:0] step_q, step_d;
    // Remembers that the previous edge was a stall, so a frozen column is not written twice.
    logic       held_q, held_d;

    // Next-state and counter sequencing.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        step_d  = step_q;
        held_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rnd_d  = 4'd0;
                step_d = PARK_C;
                if (start) begin
                    state_d = ST_RUN;
                    step_d  = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                held_d = hold;
                if (hold) begin
                    state_d = ST_RUN;
                end else if (step_q == LAST_STEP) begin
                    if (rnd_q == NR_C) begin
                        state_d = ST_OUT;
                        step_d  = PARK_C;
                    end else begin
                        step_d = 3'd0;
                        rnd_d  = rnd_q + 4'd1;
                    end
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    rnd_d   = 4'd0;
                    step_d  = PARK_C;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rnd_d   = 4'd0;
                step_d  = PARK_C;
            end
        endcase
    end

    // State, counter and stall-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rnd_q   <= 4'd0;
            step_q  <= PARK_C;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            step_q  <= step_d;
            held_q  <= held_d;
        end
    end

    assign rnd_cnt = rnd_q;
    assign step    = step_q;

    // Datapath controls decoded from registered state; done is the only input-dependent output.
    always_comb begin
        busy         = 1'b0;
        out_valid    = 1'b0;
        done         = 1'b0;
        load_key     = 1'b0;
        sbox_key     = 1'b0;
        key_word_sel = rnd_q[0];
        col_idx      = 2'd0;
        col_en       = 1'b0;
        mix_en       = 1'b0;
        first_rnd    = 1'b0;
        last_rnd     = 1'b0;
        if (state_q == ST_RUN) begin
            busy      = 1'b1;
            load_key  = (rnd_q == 4'd0) && (step_q == 3'd0);
            sbox_key  = (step_q == 3'd1);
            first_rnd = (rnd_q == 4'd0);
            last_rnd  = (rnd_q == NR_C);
            case (step_q)
                3'd0:    col_idx = 2'd0;
                3'd2:    col_idx = 2'd1;
                3'd3:    col_idx = 2'd2;
                3'd4:    col_idx = 2'd3;
                default: col_idx = 2'd0;
            endcase
            // Round 0 is AddRoundKey only, so no column is written back.
            col_en = (step_q != 3'd1) && (rnd_q != 4'd0) && !held_q;
            mix_en = col_en && (rnd_q != NR_C);
        end else if (state_q == ST_OUT) begin
            busy      = 1'b1;
            out_valid = 1'b1;
            done      = out_ready && !reset;
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_aes256_round_seq.sv
// Scoreboard bench: a progress-index model predicts every cycle's outputs; a negedge monitor compares them.
module tb_aes256_round_seq;

    logic       clk = 1'b0;
    logic       reset, start, hold, out_ready;
    logic       busy, out_valid, done;
    logic [3:0] rnd_cnt;
    logic [2:0] step;
    logic       load_key, sbox_key, key_word_sel;
    logic [1:0] col_idx;
    logic       col_en, mix_en, first_rnd, last_rnd;

    int checks = 0;
    int errors = 0;
    int exp_dones = 0;
    int obs_dones = 0;
    int cyc = 0;

    logic [17:0] exp_q[$];

    aes256_round_seq dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .out_ready(out_ready),
        .busy(busy), .out_valid(out_valid), .done(done), .rnd_cnt(rnd_cnt), .step(step),
        .load_key(load_key), .sbox_key(sbox_key), .key_word_sel(key_word_sel),
        .col_idx(col_idx), .col_en(col_en), .mix_en(mix_en),
        .first_rnd(first_rnd), .last_rnd(last_rnd)
    );

    always #5 clk = ~clk;

    // Expected outputs from phase (0 idle, 1 run, 2 out) and progress = count of advancing RUN cycles.
    function automatic logic [17:0] model_outputs(int phase, int prog, bit held);
        int r, s, ci;
        bit run, ce, me;
        run = (phase == 1);
        if (phase == 2) r = 14;
        else if (run) r = prog / 5;
        else r = 0;
        s  = run ? prog % 5 : 5;
        ci = (run && s >= 2) ? s - 1 : 0;
        ce = run && r >= 1 && s != 1 && !held;
        me = ce && r != 14;
        return {phase != 0, phase == 2, 4'(r), 3'(s), run && prog == 0, run && s == 1,
                (r % 2) == 1, 2'(ci), ce, me, run && r == 0, run && r == 14};
    endfunction

    int m_phase = 0, m_prog = 0;
    bit m_held = 1'b0, m_live = 1'b0;

    // Reference model: advances on each edge and queues the outputs expected for the coming cycle.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_phase = 0; m_prog = 0; m_held = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            case (m_phase)
                0: begin
                    m_held = 1'b0;
                    if (start) begin m_phase = 1; m_prog = 0; end
                end
                1: begin
                    m_held = hold;
                    if (!hold) begin
                        if (m_prog == 74) m_phase = 2;
                        else m_prog++;
                    end
                end
                default: begin
                    m_held = 1'b0;
                    if (out_ready) begin m_phase = 0; m_prog = 0; exp_dones++; end
                end
            endcase
        end
        if (m_live) exp_q.push_back(model_outputs(m_phase, m_prog, m_held));
    end

    // Monitor: pops the prediction for this cycle and compares all outputs including done.
    always @(negedge clk) begin
        logic [17:0] e;
        logic [18:0] exp_v, act_v;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            exp_v = {e[16] && out_ready && !reset, e};
            act_v = {done, busy, out_valid, rnd_cnt, step, load_key, sbox_key, key_word_sel,
                     col_idx, col_en, mix_en, first_rnd, last_rnd};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs cycle %0d: got %h expected %h", cyc, act_v, exp_v);
            end
            if (done === 1'b1) obs_dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; out_ready = 1'b1;
        tick_n(3);
        reset = 1'b0;
        // Plain operation: busy from cycle 1, out_valid at cycle 76, immediate accept.
        start = 1'b1; tick(); start = 1'b0;
        tick_n(85);
        // Ten-cycle stall at round 7 step 2, then result left pending for 20 cycles.
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick_n(37);
        hold = 1'b1; tick_n(10); hold = 1'b0;
        tick_n(38);
        tick_n(20);
        out_ready = 1'b1; tick_n(4);
        // Reset in the middle of round 9, then a full operation.
        start = 1'b1; tick(); start = 1'b0;
        tick_n(48);
        reset = 1'b1; tick(); reset = 1'b0;
        tick_n(2);
        start = 1'b1; tick(); start = 1'b0;
        tick_n(80);
        // start held high: back-to-back operations.
        start = 1'b1; tick_n(250); start = 1'b0;
        tick_n(5);
        // Random mix of start, hold, out_ready and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(7) == 0);
            hold      = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(1) == 1);
            reset     = ($urandom_range(499) == 0);
            tick();
        end
        reset = 1'b0; start = 1'b0; hold = 1'b0; out_ready = 1'b1;
        tick_n(100);
        @(negedge clk);
        #1;
        checks++;
        if (obs_dones != exp_dones) begin
            errors++;
            $display("FAIL done_count got %0d expected %0d", obs_dones, exp_dones);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes256_round_seq.md
Name: aes256_round_seq

Overview:
Sequencer for the AES-256 encryption core. It drives the shared round counter (rnd_cnt, 0..14) and step counter (step, 0..4) that the key-expansion and state datapaths decode. It owns the single shared S-box: in each cycle it grants the S-box to either the key-expansion word or one state column. It also provides the start/busy/result handshake to the UART wrapper.

Parameters:
NR, 14, last round index (AES-256).
NSTEP, 5, steps per round (0..NSTEP-1).
PARK_STEP, 5, step value driven while not running; must not be decoded by any datapath.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  request to encrypt the block/key currently presented; sampled only in IDLE
hold  in  1  stall; freezes counters and state while RUN
out_ready  in  1  consumer accepts result
busy  out  1  high in RUN and OUT
out_valid  out  1  result valid; high in OUT
done  out  1  one-cycle pulse on the OUT->IDLE transition
rnd_cnt  out  4  round counter to datapaths
step  out  3  step counter to datapaths
load_key  out  1  high when RUN, rnd_cnt=0, step=0
sbox_key  out  1  1 = S-box input is the key word, 0 = state column
key_word_sel  out  1  0 = k7_rot (even rnd_cnt), 1 = k3 (odd rnd_cnt); valid while sbox_key=1
col_idx  out  2  state column fed to the S-box / written back
col_en  out  1  state-column write enable
mix_en  out  1  apply MixColumns to the current column
first_rnd  out  1  rnd_cnt==0 in RUN
last_rnd  out  1  rnd_cnt==NR in RUN

Behaviour:
- States: IDLE, RUN, OUT. Encoding is free. All outputs are registered or decoded from registered state/counters only; there are no combinational input-to-output paths except done.
- Reset (from any state, including mid-RUN): state=IDLE, rnd_cnt=0, step=PARK_STEP. busy, out_valid, done, load_key, col_en, mix_en, sbox_key, first_rnd, last_rnd all 0. key_word_sel=0, col_idx=0.
- IDLE: step=PARK_STEP, rnd_cnt=0. If start=1 at a clock edge, the next cycle is RUN with rnd_cnt=0 and step=0. Otherwise stay in IDLE.
- RUN, when hold=0 at an edge:
  - step increments.
  - If step=NSTEP-1, step wraps to 0 and rnd_cnt increments.
  - If rnd_cnt=NR and step=NSTEP-1, go to OUT instead; rnd_cnt stays at NR and step goes to PARK_STEP.
- RUN, when hold=1: state, rnd_cnt and step are unchanged. Decoded outputs keep their values; col_en is forced to 0 during hold.
- RUN length with no holds: exactly (NR+1)*NSTEP = 75 cycles. busy rises the cycle after start is accepted.
- Step map within RUN:
  - step 1: sbox_key=1, col_en=0 (key expansion consumes sub_out).
  - steps 0, 2, 3, 4: sbox_key=0, col_idx = 0, 1, 2, 3 respectively. col_en=1 only when rnd_cnt>=1.
  - Round 0 is AddRoundKey only: no col_en at any step.
- mix_en = col_en and rnd_cnt != NR.
- key_word_sel = rnd_cnt[0].
- OUT: out_valid=1 and busy=1.
  - If out_ready=1 at an edge: go to IDLE, and done=1 for that same cycle (the handshake cycle).
  - out_valid stays high indefinitely until out_ready.
- start while busy is ignored; it is not queued.
- start and out_ready both high in OUT: complete the handshake and go to IDLE only. A new start is accepted no earlier than the following cycle.
- hold while not in RUN has no effect.

Test Plan:
- Reset, then start pulse at cycle 0 -> busy=1 from cycle 1; load_key=1 only at cycle 1; out_valid rises at cycle 76; rnd_cnt steps 0..14 with step cycling 0..4 and no skipped values.
- In RUN rnd_cnt=3 -> step1 shows sbox_key=1, key_word_sel=1; steps 0,2,3,4 show col_idx 0,1,2,3 with col_en=1, mix_en=1. At rnd_cnt=14 -> mix_en=0, col_en=1. At rnd_cnt=0 -> col_en=0 at all steps.
- hold=1 for 10 cycles starting at rnd_cnt=7, step=2 -> counters frozen at 7/2 and col_en=0 throughout; out_valid rises at cycle 86.
- out_ready held low for 20 cycles in OUT -> out_valid stays 1 and step stays 5; out_ready=1 -> done pulses for exactly 1 cycle, then IDLE.
- reset asserted at rnd_cnt=9, step=3 -> next cycle IDLE, rnd_cnt=0, step=5, busy=0. A following start runs the full 75 cycles.
- start held high continuously -> back-to-back operations with at least 1 IDLE cycle between done and the next busy.
